si_tag_serializer: RTL and testbench
====================================

SI_TAG_SERIALIZER -- requirements
Module: si_tag_serializer

Interface
REQ-001 SHALL have parameter NUMBER_OF_WORDS, default 4: number of tag lanes per input beat.
REQ-002 SHALL have parameter CHANNEL_COUNT, default 20: internal channel count; valid channel codes are +1..+CHANNEL_COUNT and -1..-CHANNEL_COUNT.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port s_axis_tvalid, input, 1: input beat valid.
REQ-006 SHALL have port s_axis_tready, output, 1: input beat accepted.
REQ-007 SHALL have port s_axis_tagtime, input, NUMBER_OF_WORDS x 64: per-lane tag time in 1/3 ps units.
REQ-008 SHALL have port s_axis_channel, input, NUMBER_OF_WORDS x 6 signed: per-lane channel code.
REQ-009 SHALL have port s_axis_tkeep, input, NUMBER_OF_WORDS: per-lane tag present.
REQ-010 SHALL have port m_axis_tvalid, output, 1: output tag valid.
REQ-011 SHALL have port m_axis_tready, input, 1: downstream accepts the output tag.
REQ-012 SHALL have port m_axis_tagtime, output, 64: output tag time.
REQ-013 SHALL have port m_axis_channel, output, 6 signed: output channel code.
REQ-014 SHALL have port m_axis_tlast, output, 1: output tag is the last pending tag of its input beat.

Function
REQ-015 SHALL hold one input beat in registers: a pending mask (NUMBER_OF_WORDS bits), tag times and channel codes.
REQ-016 Input handshake: s_axis_tready = (pending == 0) OR (pending is one-hot AND m_axis_tready). This is a combinational path from m_axis_tready and is intentional.
REQ-017 On an input handshake (s_axis_tvalid AND s_axis_tready), pending SHALL load the effective keep mask and the data registers SHALL load all lanes; the load overrides the clear from a simultaneous output handshake.
REQ-018 A beat whose effective keep mask is 0 SHALL be consumed in one cycle and SHALL produce no output.
REQ-019 m_axis_tvalid SHALL equal |pending.
REQ-020 The selected lane SHALL be the lowest-index set bit of pending; m_axis_tagtime and m_axis_channel SHALL come from that lane, so tags are emitted in ascending lane order.
REQ-021 m_axis_tlast SHALL equal (pending is one-hot).
REQ-022 On an output handshake, the selected pending bit SHALL be cleared.
REQ-023 Output data SHALL remain stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 Latency: the first tag of an accepted beat SHALL appear one cycle after acceptance.
REQ-025 Throughput: a beat with k tags SHALL occupy exactly k output cycles under continuous m_axis_tready, with no bubble between consecutive beats.
REQ-026 When pending == 0, m_axis_tagtime and m_axis_channel SHALL be 0.

Reset
REQ-027 While rst is low: pending = 0, data registers = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tagtime = 0, m_axis_channel = 0, s_axis_tready = 1.
REQ-028 Reset asserted mid-beat SHALL discard all pending tags; the first cycle after release SHALL behave as idle.

Configuration
REQ-029 Macro TAG_SERIALIZER_CHANNEL_FILTER_EN, when defined, SHALL add the following ports:
- input channel_enable [2*CHANNEL_COUNT-1:0]: bit n-1 enables channel +n; bit CHANNEL_COUNT+n-1 enables channel -n.
- output dropped_count [31:0]: saturating count of filtered tags.
REQ-030 With the macro defined: effective keep = s_axis_tkeep AND the per-lane channel enable; dropped_count increments by popcount of the removed lanes per accepted beat, saturates at 0xFFFFFFFF, and resets to 0.
REQ-031 Without the macro: the ports above are absent and effective keep = s_axis_tkeep.

Structure
REQ-032 Package si_tag_pkg SHALL hold:
- tagtime_t (64-bit unsigned);
- channel_t (6-bit signed);
- the CHANNEL_COUNT default;
- function channel_to_enable_index (channel code -> enable bit index).
REQ-033 Sub-module si_lowest_set_index SHALL provide the parameterized priority encoder (mask -> index, any).

Verification
REQ-034 Single beat, 4 lanes, tkeep=1011, times 100/200/300/400, m_axis_tready=1 -> three tags over 3 cycles: 100, 200, 400; tlast only on 400.
REQ-035 Back-to-back beats tkeep=1111 then 0001 with tready=1 -> 5 consecutive valid cycles, no gap; s_axis_tready high in the cycles the 4th and 5th tags are accepted.
REQ-036 m_axis_tready held low for 3 cycles with tag time 0x123 pending -> outputs stable, s_axis_tready=0 for all 3 cycles.
REQ-037 Beat with tkeep=0000 -> accepted in 1 cycle, m_axis_tvalid stays 0.
REQ-038 rst pulled low with 2 tags pending -> m_axis_tvalid=0 immediately; after release, s_axis_tready=1 and no stale tags appear.
REQ-039 With TAG_SERIALIZER_CHANNEL_FILTER_EN, channel_enable allowing only +1, beat with channels +1/-1/+2/+1 -> 2 tags output, dropped_count=2.

Source files
------------

// File: rtl/si_tag_pkg.sv
// Shared types and helpers for the tag serializer: tag time / channel types,
// default channel count and the channel-code to enable-bit mapping.
package si_tag_pkg;

  typedef logic [63:0]        tagtime_t;  // 1/3 ps units
  typedef logic signed [5:0]  channel_t;  // +1..+N, -1..-N

  localparam int CHANNEL_COUNT_DEFAULT = 20;

  // +n maps to bit n-1, -n maps to bit channel_count+n-1; anything else is -1.
  function automatic int channel_to_enable_index(input channel_t ch, input int channel_count);
    int c;
    c = int'(ch);
    if (c >= 1 && c <= channel_count) return c - 1;
    if (c <= -1 && c >= -channel_count) return channel_count - c - 1;
    return -1;
  endfunction

endpackage

// File: rtl/si_tag_serializer_if.sv
// Wide tag-beat input stream and single-tag output stream of the serializer.
// slave = serializer view, master = the environment driving it.
interface si_tag_serializer_if
  import si_tag_pkg::*;
#(
  parameter int NUMBER_OF_WORDS = 4
);
  logic                             s_axis_tvalid;
  logic                             s_axis_tready;
  tagtime_t [NUMBER_OF_WORDS-1:0]   s_axis_tagtime;
  channel_t [NUMBER_OF_WORDS-1:0]   s_axis_channel;
  logic     [NUMBER_OF_WORDS-1:0]   s_axis_tkeep;

  logic                             m_axis_tvalid;
  logic                             m_axis_tready;
  tagtime_t                         m_axis_tagtime;
  channel_t                         m_axis_channel;
  logic                             m_axis_tlast;

  modport slave (
    input  s_axis_tvalid, s_axis_tagtime, s_axis_channel, s_axis_tkeep, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tagtime, m_axis_channel, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tagtime, s_axis_channel, s_axis_tkeep, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tagtime, m_axis_channel, m_axis_tlast
  );
endinterface

// File: rtl/si_lowest_set_index.sv
// Priority encoder: index of the lowest set bit of i_mask, plus any-bit-set flag.
module si_lowest_set_index #(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_mask,
  output logic [IDX_W-1:0] o_index,
  output logic             o_any
);

  always_comb begin
    // NOTE: default assignment first so no path leaves o_index unassigned (no latch).
    o_index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_mask[i]) o_index = IDX_W'(i);
    end
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/si_tag_serializer.sv
// Serializes one beat of up to NUMBER_OF_WORDS tags into single tags, lowest lane first.
// Optional channel filter enabled by defining TAG_SERIALIZER_CHANNEL_FILTER_EN.
module si_tag_serializer
  import si_tag_pkg::*;
#(
  parameter int NUMBER_OF_WORDS = 4,
  parameter int CHANNEL_COUNT   = CHANNEL_COUNT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef TAG_SERIALIZER_CHANNEL_FILTER_EN
  input  logic [2*CHANNEL_COUNT-1:0] channel_enable,
  output logic [31:0]                dropped_count,
`endif
  si_tag_serializer_if.slave         bus
);

  localparam int IDX_W = (NUMBER_OF_WORDS > 1) ? $clog2(NUMBER_OF_WORDS) : 1;

  logic     [NUMBER_OF_WORDS-1:0] r_pending;
  tagtime_t [NUMBER_OF_WORDS-1:0] r_tagtime;
  channel_t [NUMBER_OF_WORDS-1:0] r_channel;

  logic [NUMBER_OF_WORDS-1:0] w_keep;
  logic [IDX_W-1:0]           w_sel;
  logic                       w_any;
  logic                       w_onehot;
  logic                       w_in_hs;
  logic                       w_out_hs;

  si_lowest_set_index #(
    .WIDTH (NUMBER_OF_WORDS),
    .IDX_W (IDX_W)
  ) u_sel (
    .i_mask  (r_pending),
    .o_index (w_sel),
    .o_any   (w_any)
  );

  assign w_onehot = w_any && ((r_pending & (r_pending - NUMBER_OF_WORDS'(1))) == '0);

  // Accepting while the last tag leaves keeps beats back-to-back without a bubble.
  assign bus.s_axis_tready = !w_any || (w_onehot && bus.m_axis_tready);
  assign w_in_hs           = bus.s_axis_tvalid && bus.s_axis_tready;
  assign w_out_hs          = w_any && bus.m_axis_tready;

  assign bus.m_axis_tvalid  = w_any;
  assign bus.m_axis_tlast   = w_onehot;
  assign bus.m_axis_tagtime = w_any ? r_tagtime[w_sel] : '0;
  assign bus.m_axis_channel = w_any ? r_channel[w_sel] : '0;

`ifdef TAG_SERIALIZER_CHANNEL_FILTER_EN
  logic [NUMBER_OF_WORDS-1:0] w_drop;
  logic [32:0]                w_drop_sum;
  logic [31:0]                r_dropped;

  always_comb begin
    int                       idx;
    logic [2*CHANNEL_COUNT-1:0] en_sh;
    w_keep = '0;
    idx    = -1;
    en_sh  = '0;
    for (int i = 0; i < NUMBER_OF_WORDS; i++) begin
      idx       = channel_to_enable_index(bus.s_axis_channel[i], CHANNEL_COUNT);
      en_sh     = (idx >= 0) ? (channel_enable >> idx) : '0;
      w_keep[i] = bus.s_axis_tkeep[i] && en_sh[0];
    end
  end

  assign w_drop     = bus.s_axis_tkeep & ~w_keep;
  assign w_drop_sum = {1'b0, r_dropped} + 33'($countones(w_drop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dropped <= '0;
    end else if (w_in_hs) begin
      r_dropped <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
    end
  end

  assign dropped_count = r_dropped;
`else
  assign w_keep = bus.s_axis_tkeep;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: data registers are reset too, so nothing stale can reach the outputs.
      r_pending <= '0;
      r_tagtime <= '0;
      r_channel <= '0;
    end else if (w_in_hs) begin
      // NOTE: non-blocking updates; a new beat overrides the clear of the last tag.
      r_pending <= w_keep;
      r_tagtime <= bus.s_axis_tagtime;
      r_channel <= bus.s_axis_channel;
    end else if (w_out_hs) begin
      r_pending[w_sel] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_si_tag_serializer.sv
// Self-checking bench for si_tag_serializer: queue-based tag model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_si_tag_serializer;
  import si_tag_pkg::*;

  localparam int NW = 4;
  localparam int CC = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  si_tag_serializer_if #(.NUMBER_OF_WORDS(NW)) bus ();

`ifdef TAG_SERIALIZER_CHANNEL_FILTER_EN
  logic [2*CC-1:0] channel_enable;
  logic [31:0]     dropped_count;
`endif

  si_tag_serializer #(
    .NUMBER_OF_WORDS (NW),
    .CHANNEL_COUNT   (CC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef TAG_SERIALIZER_CHANNEL_FILTER_EN
    .channel_enable (channel_enable),
    .dropped_count  (dropped_count),
`endif
    .bus            (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: the tags still owed by the current beat, in order
  typedef struct {
    logic [63:0]       t;
    logic signed [5:0] c;
  } tag_s;
  tag_s cur[$];
  int unsigned m_drop;

`ifdef TAG_SERIALIZER_CHANNEL_FILTER_EN
  function automatic bit lane_enabled(input logic signed [5:0] ch);
    int c;
    logic [2*CC-1:0] sh;
    c = int'(ch);
    if (c >= 1 && c <= CC) begin
      sh = channel_enable >> (c - 1);
      return sh[0];
    end
    if (c <= -1 && c >= -CC) begin
      sh = channel_enable >> (CC - c - 1);
      return sh[0];
    end
    return 1'b0;
  endfunction
`endif

  always @(posedge clk or negedge rst) begin
    bit   rdy;
    int   dropped;
    tag_s tg;
    if (!rst) begin
      cur.delete();
      m_drop = 0;
    end else begin
      rdy = (cur.size() == 0) || (cur.size() == 1 && bus.m_axis_tready);
      if (cur.size() > 0 && bus.m_axis_tready) void'(cur.pop_front());
      if (bus.s_axis_tvalid && rdy) begin
        cur.delete();
        dropped = 0;
        for (int i = 0; i < NW; i++) begin
          if (bus.s_axis_tkeep[i]) begin
            tg.t = bus.s_axis_tagtime[i];
            tg.c = bus.s_axis_channel[i];
`ifdef TAG_SERIALIZER_CHANNEL_FILTER_EN
            if (lane_enabled(tg.c)) cur.push_back(tg);
            else dropped++;
`else
            cur.push_back(tg);
`endif
          end
        end
        if (m_drop + dropped > 32'hFFFF_FFFF || m_drop + dropped < m_drop) m_drop = 32'hFFFF_FFFF;
        else m_drop = m_drop + dropped;
      end
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    bit               ev;
    logic [63:0]      et;
    logic signed [5:0] ec;
    ev = cur.size() > 0;
    et = ev ? cur[0].t : 64'd0;
    ec = ev ? cur[0].c : 6'sd0;
    check("m_tvalid", 64'(bus.m_axis_tvalid), 64'(ev));
    check("m_tlast", 64'(bus.m_axis_tlast), 64'(cur.size() == 1));
    check("m_tagtime", bus.m_axis_tagtime, et);
    check("m_channel", {58'd0, bus.m_axis_channel}, {58'd0, ec});
    check("s_tready", 64'(bus.s_axis_tready),
          64'((cur.size() == 0) || (cur.size() == 1 && bus.m_axis_tready)));
`ifdef TAG_SERIALIZER_CHANNEL_FILTER_EN
    check("dropped_count", 64'(dropped_count), 64'(m_drop));
`endif
  end

  // ---------------- output log and cycle counter
  typedef struct {
    logic [63:0]       t;
    logic signed [5:0] c;
    bit                last;
    bit                srdy;
    int                edge_n;
  } log_s;
  log_s lg[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && bus.m_axis_tvalid && bus.m_axis_tready)
      lg.push_back('{bus.m_axis_tagtime, bus.m_axis_channel, bus.m_axis_tlast,
                     bus.s_axis_tready, cyc + 1});
  end

  bit tog_en = 1'b0;
  always @(posedge clk) begin
    if (tog_en) begin
      #1 bus.m_axis_tready = (cyc % 3) != 0;
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [NW-1:0] keep,
                           input logic [63:0] t0, input logic [63:0] t1,
                           input logic [63:0] t2, input logic [63:0] t3,
                           input int c0, input int c1, input int c2, input int c3,
                           output int waited, output int acc_edge);
    bit acc;
    bus.s_axis_tkeep      = keep;
    bus.s_axis_tagtime[0] = t0;
    bus.s_axis_tagtime[1] = t1;
    bus.s_axis_tagtime[2] = t2;
    bus.s_axis_tagtime[3] = t3;
    bus.s_axis_channel[0] = 6'(c0);
    bus.s_axis_channel[1] = 6'(c1);
    bus.s_axis_channel[2] = 6'(c2);
    bus.s_axis_channel[3] = 6'(c3);
    bus.s_axis_tvalid     = 1'b1;
    waited = 0;
    acc    = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = bus.s_axis_tready;
      tick();
      waited++;
    end
    acc_edge = cyc;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (cur.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (cur.size() != 0) check("drain_timeout", 64'd0, 64'd1);
    tick();
  endtask

  logic [63:0] e34_t[3] = '{64'd100, 64'd200, 64'd400};
  int          e34_c[3] = '{1, 2, 4};

  initial begin
    int w, a1, a2;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tagtime = '0;
    bus.s_axis_channel = '0;
    bus.m_axis_tready = 1'b1;
`ifdef TAG_SERIALIZER_CHANNEL_FILTER_EN
    channel_enable = '1;
`endif

    // Reset values while rst is held low
    repeat (2) @(negedge clk);
    check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("rst_sready", 64'(bus.s_axis_tready), 64'd1);
    check("rst_tagtime", bus.m_axis_tagtime, 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single beat, keep 1011: tags 100, 200, 400, tlast only on 400
    lg.delete();
    send_beat(4'b1011, 64'd100, 64'd200, 64'd300, 64'd400, 1, 2, 3, 4, w, a1);
    bus.s_axis_tvalid = 1'b0;
    drain();
    check("t34_count", 64'(lg.size()), 64'd3);
    for (int i = 0; i < 3 && i < lg.size(); i++) begin
      check("t34_time", lg[i].t, e34_t[i]);
      check("t34_chan", 64'(int'(lg[i].c)), 64'(e34_c[i]));
      check("t34_last", 64'(lg[i].last), 64'(i == 2));
      check("t34_edge", 64'(lg[i].edge_n - a1), 64'(i + 1));
    end

    // Back-to-back beats 1111 then 0001: five consecutive tags
    lg.delete();
    send_beat(4'b1111, 64'h10, 64'h11, 64'h12, 64'h13, 5, 6, -7, 8, w, a1);
    send_beat(4'b0001, 64'h20, 64'h21, 64'h22, 64'h23, -20, 1, 1, 1, w, a2);
    bus.s_axis_tvalid = 1'b0;
    drain();
    check("t35_acc_gap", 64'(a2 - a1), 64'd4);
    check("t35_count", 64'(lg.size()), 64'd5);
    if (lg.size() == 5) begin
      check("t35_span", 64'(lg[4].edge_n - lg[0].edge_n), 64'd4);
      check("t35_first", 64'(lg[0].edge_n - a1), 64'd1);
      check("t35_srdy4", 64'(lg[3].srdy), 64'd1);
      check("t35_srdy5", 64'(lg[4].srdy), 64'd1);
      check("t35_last4", 64'(lg[3].last), 64'd1);
      check("t35_time5", lg[4].t, 64'h20);
    end

    // Stall: tready low 3 cycles with 0x123 pending
    bus.m_axis_tready = 1'b0;
    send_beat(4'b0001, 64'h123, 64'h0, 64'h0, 64'h0, 3, 1, 1, 1, w, a1);
    bus.s_axis_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t36_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
      check("t36_time", bus.m_axis_tagtime, 64'h123);
      check("t36_sready", 64'(bus.s_axis_tready), 64'd0);
      tick();
    end
    bus.m_axis_tready = 1'b1;
    drain();

    // Empty beat: consumed in one cycle, no output
    lg.delete();
    send_beat(4'b0000, 64'h5, 64'h6, 64'h7, 64'h8, 1, 2, 3, 4, w, a1);
    bus.s_axis_tvalid = 1'b0;
    check("t37_wait", 64'(w), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t37_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      tick();
    end
    check("t37_count", 64'(lg.size()), 64'd0);

    // Reset with two tags pending
    bus.m_axis_tready = 1'b0;
    send_beat(4'b0011, 64'h31, 64'h32, 64'h33, 64'h34, 1, 2, 3, 4, w, a1);
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t38_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("t38_tlast", 64'(bus.m_axis_tlast), 64'd0);
    check("t38_sready", 64'(bus.s_axis_tready), 64'd1);
    tick();
    rst = 1'b1;
    bus.m_axis_tready = 1'b1;
    lg.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t38_idle_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      check("t38_idle_sready", 64'(bus.s_axis_tready), 64'd1);
      tick();
    end
    check("t38_stale", 64'(lg.size()), 64'd0);

    // Irregular downstream ready with mixed beats; model checks every cycle
    tog_en = 1'b1;
    lg.delete();
    send_beat(4'b0110, 64'hA0, 64'hA1, 64'hA2, 64'hA3, -5, 7, -9, 11, w, a1);
    send_beat(4'b1001, 64'hB0, 64'hB1, 64'hB2, 64'hB3, 20, -1, 2, -20, w, a1);
    send_beat(4'b1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'hC1, 64'hC2, 64'hC3, 1, -2, 3, -4, w, a1);
    bus.s_axis_tvalid = 1'b0;
    drain();
    tog_en = 1'b0;
    #2 bus.m_axis_tready = 1'b1;
    tick();
    check("mix_count", 64'(lg.size()), 64'd8);
    if (lg.size() == 8) begin
      check("mix_first", lg[0].t, 64'hA1);
      check("mix_b_last", lg[3].t, 64'hB3);
      check("mix_max", lg[4].t, 64'hFFFF_FFFF_FFFF_FFFF);
    end

`ifdef TAG_SERIALIZER_CHANNEL_FILTER_EN
    // Only +1 enabled: channels +1/-1/+2/+1 -> two tags, two dropped
    channel_enable = '0;
    channel_enable[0] = 1'b1;
    lg.delete();
    send_beat(4'b1111, 64'hD0, 64'hD1, 64'hD2, 64'hD3, 1, -1, 2, 1, w, a1);
    bus.s_axis_tvalid = 1'b0;
    drain();
    check("t39_count", 64'(lg.size()), 64'd2);
    check("t39_dropped", 64'(dropped_count), 64'd2);
    if (lg.size() == 2) begin
      check("t39_t0", lg[0].t, 64'hD0);
      check("t39_t1", lg[1].t, 64'hD3);
    end
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
